tile_n_calc_seq: RTL and testbench
==================================

Name: tile_n_calc_seq

Overview:
- Sequential, parametrised successor to the combinational tile_n calculator.
- Computes the maximum tile_n that fits the GLB budget for PW/DW/STD/LIN layers.
- Uses a shared serial restoring divider instead of combinational dividers, a start/done handshake, a budget-underflow/zero-divisor error flag, clamping to TILE_N_MAX, and a parametrised PW alignment.
- Sits in the layer-setup path between the layer descriptor decoder and the tile scheduler.

Parameters:
- GLB_BYTES, `GLB_MAX_BYTES: GLB capacity in bytes.
- BYTES_I, `BYTES_I: activation bytes per element.
- BYTES_W, `BYTES_W: weight bytes per element.
- BYTES_P, `BYTES_P: partial-sum bytes per element.
- CH_W, 7: width of channel, tile and M inputs.
- K_W, 2: width of kernel height/width inputs.
- ACC_W, 32: internal arithmetic and tile_n width; divider iteration count.
- ALIGN_PW, 4: PW tile_n alignment (power of two, >=1).
- TILE_N_MAX, 4095: upper clamp on tile_n.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- layer_type  in  2  0=PW, 1=DW, 2=STD, 3=LIN
- out_C  in  CH_W  output channels
- kH, kW  in  K_W each  kernel dims
- tile_D, tile_K  in  CH_W each  ifmap/opsum tile channels
- tile_D_f, tile_K_f  in  CH_W each  filter tile channels
- M  in  CH_W  ifmap row-buffer depth
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse; tile_n/err valid
- tile_n  out  ACC_W  result, held until next done
- err  out  1  result invalid, held until next done

Behaviour:
- Reset value of every output: busy=0, done=0, tile_n=0, err=0; FSM goes to IDLE. A reset mid-operation aborts the calculation with no done.
- Inputs are registered on accepted start; they may change afterwards. start while busy is ignored.
- Arithmetic is at ACC_W, unsigned:
  - tmp1 = kH*kW*tile_D_f*tile_K_f*BYTES_W
  - tmp2 = tile_D*BYTES_I + tile_K*BYTES_P
  - tmp3 = M*tile_D*BYTES_I
  - avail = GLB_BYTES - tmp1 - tmp3
- States:
  - IDLE: start=1 -> PREP.
  - PREP (1 cycle): compute tmp1..tmp3 into registers.
    - If tmp1+tmp3 > GLB_BYTES, or tmp2==0, or (layer_type in {DW,STD} and out_C==0): set err path -> DONE.
    - Otherwise load the divider with avail/tmp2 -> DIV1.
  - DIV1 (ACC_W cycles): restoring division, one quotient bit per cycle, MSB first; n_max = quotient.
    - PW or LIN -> FIN.
    - DW or STD -> reload the divider with n_max/out_C -> DIV2.
  - DIV2 (ACC_W cycles): q2 = quotient -> FIN.
  - FIN (1 cycle):
    - Candidate r = n_max for PW/LIN, q2 for DW/STD.
    - r = min(r, TILE_N_MAX).
    - PW only: clear the low log2(ALIGN_PW) bits.
    - Register tile_n=r, err=0 -> DONE.
  - DONE (1 cycle): done=1 -> IDLE. On the err path: tile_n=0, err=1.
- busy=1 in PREP, DIV1, DIV2, FIN; busy=0 in DONE and IDLE.
- Latency from the start-sampling edge to the done-high cycle:
  - PW/LIN: ACC_W+3 cycles (35 at default).
  - DW/STD: 2*ACC_W+3 cycles (67 at default).
  - Error: 2 cycles.
- start in the DONE cycle is ignored; start the cycle after done is accepted, giving back-to-back operation.
- Boundary cases:
  - avail == 0 gives tile_n=0, err=0.
  - Quotient below ALIGN_PW on PW gives tile_n=0, err=0.

Decomposition:
- Shared package (define.svh/pkg) holds:
  - Layer-type constants POINTWISE/DEPTHWISE/STANDARD/LINEAR.
  - An FSM state enum typedef tile_n_state_e.
  - Default widths.
- Sub-module serial_divider #(W): inputs start, dividend, divisor; outputs quotient, done.
  - W-cycle restoring divider, reused for both divisions.
  - Its divisor==0 behaviour is don't-care because this block never issues it.

Test Plan:
- Test Plan common setup: GLB=65536, BYTES_I=1, BYTES_W=1, BYTES_P=2, defaults otherwise.
- PW: k=1x1, tile_D=32, tile_K=20, tile_D_f=32, tile_K_f=20, M=0 -> 64896/72=901 -> aligned tile_n=900, err=0, done 35 cycles after start.
- DW: k=3x3, tile_D=16, tile_K=16, tile_D_f=1, tile_K_f=16, M=8, out_C=32 -> n_max=65264/48=1359 -> tile_n=42, done at cycle 67.
- Clamp: PW, all tiles=1, k=1x1, M=0 -> 65535/3=21845 -> clamp 4095 -> aligned 4092; the same inputs as LIN give 4095.
- Error: k=3x3, tile_D_f=tile_K_f=127 -> tmp1=145161 > GLB -> err=1, tile_n=0, done 2 cycles after start. Separately, DW with out_C=0 -> err=1.
- Handshake/reset:
  - start pulses mid-DIV1 are ignored, giving exactly one done.
  - rst asserted mid-DIV2 -> all outputs 0 immediately, no done.
  - A new start the cycle after done gives a correct second result.

Source files
------------

// File: rtl/tile_n_calc_seq_pkg.sv
// Shared constants for the sequential tile_n calculator: layer-type codes,
// FSM state encoding and default parameter values.
package tile_n_calc_seq_pkg;

    localparam logic [1:0] POINTWISE = 2'd0;
    localparam logic [1:0] DEPTHWISE = 2'd1;
    localparam logic [1:0] STANDARD  = 2'd2;
    localparam logic [1:0] LINEAR    = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_DIV1,
        S_DIV2,
        S_FIN,
        S_DONE
    } tile_n_state_e;

    localparam int DEF_GLB_BYTES  = 65536;
    localparam int DEF_BYTES_I    = 1;
    localparam int DEF_BYTES_W    = 1;
    localparam int DEF_BYTES_P    = 2;
    localparam int DEF_CH_W       = 7;
    localparam int DEF_K_W        = 2;
    localparam int DEF_ACC_W      = 32;
    localparam int DEF_ALIGN_PW   = 4;
    localparam int DEF_TILE_N_MAX = 4095;

endpackage

// File: rtl/tile_n_calc_seq_serial_divider.sv
// W-cycle restoring divider. The start edge performs the first quotient bit,
// so done pulses in the cycle after the W-th bit has been produced.
module serial_divider #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic         done
);

    logic [W-1:0]         rem, quo, dvr;
    logic [$clog2(W+1)-1:0] cnt;
    logic [W-1:0]         rem_in, q_in, dv, rem_nx, q_nx;
    logic [W:0]           trial;
    logic                 ge;

    // On start the step is fed from the inputs rather than the registers.
    always_comb begin
        rem_in = start ? '0 : rem;
        q_in   = start ? dividend : quo;
        dv     = start ? divisor : dvr;
        trial  = {rem_in, q_in[W-1]};
        ge     = trial >= {1'b0, dv};
        rem_nx = ge ? W'(trial - {1'b0, dv}) : trial[W-1:0];
        q_nx   = {q_in[W-2:0], ge};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem  <= '0;
            quo  <= '0;
            dvr  <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else if (start) begin
            rem  <= rem_nx;
            quo  <= q_nx;
            dvr  <= divisor;
            cnt  <= ($clog2(W+1))'(W - 1);
            done <= (W == 1);
        end else if (cnt != '0) begin
            rem  <= rem_nx;
            quo  <= q_nx;
            cnt  <= cnt - 1'b1;
            done <= (cnt == 1);
        end else begin
            done <= 1'b0;
        end
    end

    assign quotient = quo;

endmodule

// File: rtl/tile_n_calc_seq.sv
// Sequential tile_n calculator: largest tile_n fitting the GLB budget,
// using one shared serial divider for avail/tmp2 and, for DW/STD, n_max/out_C.
module tile_n_calc_seq
    import tile_n_calc_seq_pkg::*;
#(
    parameter int GLB_BYTES  = DEF_GLB_BYTES,
    parameter int BYTES_I    = DEF_BYTES_I,
    parameter int BYTES_W    = DEF_BYTES_W,
    parameter int BYTES_P    = DEF_BYTES_P,
    parameter int CH_W       = DEF_CH_W,
    parameter int K_W        = DEF_K_W,
    parameter int ACC_W      = DEF_ACC_W,
    parameter int ALIGN_PW   = DEF_ALIGN_PW,
    parameter int TILE_N_MAX = DEF_TILE_N_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       layer_type,
    input  logic [CH_W-1:0]  out_C,
    input  logic [K_W-1:0]   kH,
    input  logic [K_W-1:0]   kW,
    input  logic [CH_W-1:0]  tile_D,
    input  logic [CH_W-1:0]  tile_K,
    input  logic [CH_W-1:0]  tile_D_f,
    input  logic [CH_W-1:0]  tile_K_f,
    input  logic [CH_W-1:0]  M,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] tile_n,
    output logic             err
);

    localparam logic [ACC_W-1:0] GLB        = ACC_W'(GLB_BYTES);
    localparam logic [ACC_W-1:0] TMAX       = ACC_W'(TILE_N_MAX);
    localparam logic [ACC_W-1:0] ALIGN_MASK = ~(ACC_W'(ALIGN_PW) - 1'b1);

    tile_n_state_e    state;
    logic [1:0]       lt_r;
    logic [CH_W-1:0]  oc_r, td_r, tk_r, tdf_r, tkf_r, m_r;
    logic [K_W-1:0]   kh_r, kw_r;

    logic [ACC_W-1:0] tmp1, tmp2, tmp3, avail, quotient, div_dividend, div_divisor;
    logic [ACC_W-1:0] clamped, cand;
    logic             over, bad, two_pass, div_start, div_done;

    always_comb begin
        tmp1 = ACC_W'(kh_r) * ACC_W'(kw_r) * ACC_W'(tdf_r) * ACC_W'(tkf_r) * ACC_W'(BYTES_W);
        tmp2 = ACC_W'(td_r) * ACC_W'(BYTES_I) + ACC_W'(tk_r) * ACC_W'(BYTES_P);
        tmp3 = ACC_W'(m_r) * ACC_W'(td_r) * ACC_W'(BYTES_I);
        avail = GLB - tmp1 - tmp3;
        // One extra bit so a large footprint cannot wrap into a false fit.
        over = ({1'b0, tmp1} + {1'b0, tmp3}) > {1'b0, GLB};
        two_pass = (lt_r == DEPTHWISE) || (lt_r == STANDARD);
        bad = over || (tmp2 == '0) || (two_pass && (oc_r == '0));
        div_start = ((state == S_PREP) && !bad) ||
                    ((state == S_DIV1) && div_done && two_pass);
        div_dividend = (state == S_PREP) ? avail : quotient;
        div_divisor  = (state == S_PREP) ? tmp2 : ACC_W'(oc_r);
        // The divider holds its last quotient: n_max for PW/LIN, q2 for DW/STD.
        clamped = (quotient > TMAX) ? TMAX : quotient;
        cand = (lt_r == POINTWISE) ? (clamped & ALIGN_MASK) : clamped;
    end

    serial_divider #(.W(ACC_W)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .quotient (quotient),
        .done     (div_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            tile_n <= '0;
            err    <= 1'b0;
            lt_r   <= '0;
            oc_r   <= '0;
            td_r   <= '0;
            tk_r   <= '0;
            tdf_r  <= '0;
            tkf_r  <= '0;
            m_r    <= '0;
            kh_r   <= '0;
            kw_r   <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    lt_r  <= layer_type;
                    oc_r  <= out_C;
                    td_r  <= tile_D;
                    tk_r  <= tile_K;
                    tdf_r <= tile_D_f;
                    tkf_r <= tile_K_f;
                    m_r   <= M;
                    kh_r  <= kH;
                    kw_r  <= kW;
                    busy  <= 1'b1;
                    state <= S_PREP;
                end
                S_PREP: if (bad) begin
                    tile_n <= '0;
                    err    <= 1'b1;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= S_DONE;
                end else begin
                    state  <= S_DIV1;
                end
                S_DIV1: if (div_done) state <= two_pass ? S_DIV2 : S_FIN;
                S_DIV2: if (div_done) state <= S_FIN;
                S_FIN: begin
                    tile_n <= cand;
                    err    <= 1'b0;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_n_calc_seq.sv
// Bench for tile_n_calc_seq: directed plan cases, handshake/reset scenarios
// and random operations scored against a plain-arithmetic reference model.
module tb_tile_n_calc_seq;

    localparam int ACC_W = 32;
    localparam int GLB   = 65536;
    localparam int BI    = 1;
    localparam int BW    = 1;
    localparam int BP    = 2;
    localparam int TMAX  = 4095;
    localparam int ALIGN = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  layer_type = '0;
    logic [6:0]  out_C = '0, tile_D = '0, tile_K = '0, tile_D_f = '0, tile_K_f = '0, M = '0;
    logic [1:0]  kH = '0, kW = '0;
    logic        busy, done, err;
    logic [31:0] tile_n;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    tile_n_calc_seq #(
        .GLB_BYTES(GLB), .BYTES_I(BI), .BYTES_W(BW), .BYTES_P(BP),
        .CH_W(7), .K_W(2), .ACC_W(ACC_W), .ALIGN_PW(ALIGN), .TILE_N_MAX(TMAX)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .layer_type(layer_type),
        .out_C(out_C), .kH(kH), .kW(kW), .tile_D(tile_D), .tile_K(tile_K),
        .tile_D_f(tile_D_f), .tile_K_f(tile_K_f), .M(M),
        .busy(busy), .done(done), .tile_n(tile_n), .err(err)
    );

    function automatic void model(input int lt, oc, kh, kw, td, tk, tdf, tkf, m,
                                  output longint t, output bit e, output int lat);
        longint t1, t2, t3, n;
        t1 = longint'(kh) * kw * tdf * tkf * BW;
        t2 = longint'(td) * BI + longint'(tk) * BP;
        t3 = longint'(m) * td * BI;
        e = (t1 + t3 > GLB) || (t2 == 0) || ((lt == 1 || lt == 2) && oc == 0);
        if (e) begin
            t = 0;
            lat = 2;
            return;
        end
        n = (GLB - t1 - t3) / t2;
        if (lt == 1 || lt == 2) begin
            n = n / oc;
            lat = 2 * ACC_W + 3;
        end else begin
            lat = ACC_W + 3;
        end
        if (n > TMAX) n = TMAX;
        if (lt == 0) n = n - (n % ALIGN);
        t = n;
    endfunction

    task automatic drive(input int lt, oc, kh, kw, td, tk, tdf, tkf, m);
        layer_type = 2'(lt);
        out_C = 7'(oc);
        kH = 2'(kh);
        kW = 2'(kw);
        tile_D = 7'(td);
        tile_K = 7'(tk);
        tile_D_f = 7'(tdf);
        tile_K_f = 7'(tkf);
        M = 7'(m);
    endtask

    task automatic scramble();
        drive($urandom_range(0, 3), $urandom_range(0, 127), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 127), $urandom_range(0, 127),
              $urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 127));
    endtask

    // Called one time unit after a rising edge in IDLE; returns likewise in the
    // cycle after done, so consecutive calls exercise back-to-back starts.
    task automatic run_op(input string name, input int lt, oc, kh, kw, td, tk, tdf, tkf, m,
                          input bit start_in_done);
        longint et;
        bit ee, busy_ok;
        int el, k;
        model(lt, oc, kh, kw, td, tk, tdf, tkf, m, et, ee, el);
        drive(lt, oc, kh, kw, td, tk, tdf, tkf, m);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        scramble();
        k = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && k < 200) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            k++;
        end
        total++;
        if (k != el) begin
            bad++;
            $display("FAIL %s latency: got %0d want %0d", name, k, el);
        end
        total++;
        if (tile_n !== 32'(et)) begin
            bad++;
            $display("FAIL %s tile_n: got %0d want %0d", name, tile_n, et);
        end
        total++;
        if (err !== ee) begin
            bad++;
            $display("FAIL %s err: got %b want %b", name, err, ee);
        end
        total++;
        if (!busy_ok || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s busy: in-flight ok=%b at done=%b want 1/0", name, busy_ok, busy);
        end
        if (start_in_done) scramble();
        start = start_in_done;
        @(posedge clk); #1;
        start = 1'b0;
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || tile_n !== 32'(et) || err !== ee) begin
            bad++;
            $display("FAIL %s hold: done=%b busy=%b tile_n=%0d err=%b want 0/0/%0d/%b",
                     name, done, busy, tile_n, err, et, ee);
        end
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || tile_n !== 32'd0 || err !== 1'b0) begin
            bad++;
            $display("FAIL reset: busy=%b done=%b tile_n=%0d err=%b want all 0", busy, done, tile_n, err);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_pw();
        run_op("pw", 0, 5, 1, 1, 32, 20, 32, 20, 0, 1'b0);
    endtask

    task automatic test_dw();
        run_op("dw", 1, 32, 3, 3, 16, 16, 1, 16, 8, 1'b0);
    endtask

    task automatic test_clamp();
        run_op("clamp_pw", 0, 0, 1, 1, 1, 1, 1, 1, 0, 1'b0);
        run_op("clamp_lin", 3, 0, 1, 1, 1, 1, 1, 1, 0, 1'b0);
    endtask

    task automatic test_errors();
        run_op("err_budget", 0, 10, 3, 3, 8, 8, 127, 127, 0, 1'b0);
        run_op("err_dw_oc0", 1, 0, 3, 3, 16, 16, 1, 16, 8, 1'b0);
        run_op("err_tmp2", 3, 4, 1, 1, 0, 0, 4, 4, 0, 1'b0);
    endtask

    task automatic test_boundaries();
        run_op("avail_zero", 0, 1, 3, 3, 32, 8, 112, 64, 32, 1'b0);
        run_op("below_align", 0, 1, 3, 3, 127, 127, 112, 64, 0, 1'b0);
        run_op("std", 2, 7, 2, 3, 40, 30, 10, 12, 20, 1'b0);
    endtask

    task automatic test_back_to_back();
        // The start held during the DONE cycle must not launch an operation.
        run_op("b2b_a", 3, 1, 1, 1, 10, 10, 10, 10, 5, 1'b1);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL done_cycle_start: busy=%b want 0", busy);
        end
        run_op("b2b_b", 0, 1, 2, 2, 20, 5, 6, 7, 9, 1'b0);
        run_op("b2b_c", 1, 9, 3, 3, 16, 16, 1, 16, 8, 1'b0);
    endtask

    task automatic test_ignore_start();
        int ndone, kdone;
        logic [31:0] tn;
        ndone = 0;
        kdone = 0;
        tn = '0;
        drive(1, 32, 3, 3, 16, 16, 1, 16, 8);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 150; k++) begin
            if (done === 1'b1) begin
                ndone++;
                kdone = k;
                tn = tile_n;
            end
            if (k == 5 || k == 20) begin
                scramble();
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        total++;
        if (ndone != 1 || kdone != 67 || tn !== 32'd42) begin
            bad++;
            $display("FAIL ignore_start: dones=%0d at=%0d tile_n=%0d want 1/67/42", ndone, kdone, tn);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        drive(1, 32, 3, 3, 16, 16, 1, 16, 8);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (45) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b1 || tile_n !== 32'd42) begin
            bad++;
            $display("FAIL pre_reset: busy=%b tile_n=%0d want 1/42", busy, tile_n);
        end
        rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || tile_n !== 32'd0 || err !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: busy=%b done=%b tile_n=%0d err=%b want all 0", busy, done, tile_n, err);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL after_reset: activity=%b want 0", seen);
        end
        run_op("post_reset", 1, 32, 3, 3, 16, 16, 1, 16, 8, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_op("rand", $urandom_range(0, 3), $urandom_range(0, 127), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 127), $urandom_range(0, 127),
                   $urandom_range(0, 50), $urandom_range(0, 50), $urandom_range(0, 127), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_pw();
        test_dw();
        test_clamp();
        test_errors();
        test_boundaries();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
